// File: rtl/sha224_digest_serializer_pkg.sv
// Shared constants, FSM state type and byte-swap helper for the SHA-224 digest serializer.
// SHA224_SER_BSWAP_EN (optional) selects little-endian byte order for each output word.
package sha224_ser_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 7;
    localparam int DIGEST_W  = WORD_W * NUM_WORDS;
    localparam int IDX_W     = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sha224_digest_serializer_if.sv
// Digest-in / word-out handshake bundle; slave is the serializer, master is the driving side.
// Handshake rule: a transfer happens on a rising edge where valid and ready are both high;
// valid never depends on ready, and the sender holds its data stable until the transfer.
interface sha224_digest_serializer_if;
    import sha224_ser_pkg::*;

    logic [DIGEST_W-1:0] digest_in;
    logic                digest_valid;
    logic                digest_ready;
    logic [WORD_W-1:0]   word_out;
    logic                word_valid;
    logic                word_ready;
    logic                word_last;
    logic [IDX_W-1:0]    word_idx;
    logic                busy;
    state_t              dbg_state;

    modport slave (
        input  digest_in, digest_valid, word_ready,
        output digest_ready, word_out, word_valid, word_last, word_idx, busy, dbg_state
    );

    modport master (
        output digest_in, digest_valid, word_ready,
        input  digest_ready, word_out, word_valid, word_last, word_idx, busy, dbg_state
    );

endinterface

// File: rtl/sha224_digest_serializer.sv
// Captures one 224-bit digest and streams it out as seven 32-bit words, MSW first.
// Define SHA224_SER_BSWAP_EN to byte-reverse every output word.
module sha224_digest_serializer
    import sha224_ser_pkg::*;
(
    input  logic                        CLK,
    input  logic                        RST,
    sha224_digest_serializer_if.slave   bus
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DIGEST_W-1:0] r_shift;
    logic [IDX_W-1:0]    r_idx;

    logic w_is_last;
    logic w_accept;
    logic w_digest_ready;
    logic w_load;

    assign w_is_last      = (r_state == SEND) && (r_idx == IDX_W'(NUM_WORDS - 1));
    assign w_accept       = (r_state == SEND) && bus.word_ready;
    // Ready early on the final accepted word so a waiting digest loads with no bubble.
    assign w_digest_ready = (r_state == IDLE) || (w_is_last && bus.word_ready);
    assign w_load         = w_digest_ready && bus.digest_valid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (bus.digest_valid) w_state_nxt = SEND;
            SEND: if (w_accept && w_is_last && !bus.digest_valid) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (w_load) begin
            r_shift <= bus.digest_in;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_shift <= {r_shift[DIGEST_W-WORD_W-1:0], {WORD_W{1'b0}}};
            r_idx   <= w_is_last ? '0 : r_idx + 1'b1;
        end
    end

    assign bus.digest_ready = w_digest_ready;
    assign bus.word_valid   = (r_state == SEND);
    assign bus.busy         = (r_state == SEND);
    assign bus.word_last    = w_is_last;
    assign bus.word_idx     = r_idx;
    assign bus.dbg_state    = r_state;

`ifdef SHA224_SER_BSWAP_EN
    assign bus.word_out = bswap32(r_shift[DIGEST_W-1 -: WORD_W]);
`else
    assign bus.word_out = r_shift[DIGEST_W-1 -: WORD_W];
`endif

endmodule

// File: tb/tb_sha224_digest_serializer.sv
// Randomized bench for sha224_digest_serializer against a word-queue reference model.
// Compile with SHA224_SER_BSWAP_EN to check the byte-reversed word order.
module tb_sha224_digest_serializer;
    import sha224_ser_pkg::*;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    sha224_digest_serializer_if bus ();

    sha224_digest_serializer dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    int          checks  = 0;
    int          errors  = 0;
    logic [31:0] exp_q[$];
    int          idx_q[$];
    int          ready_mode = 0;
    int          tog        = 0;
    bit          started    = 1'b0;

    localparam logic [223:0] KAT =
        224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7;
    localparam logic [223:0] PAT_A5 = {7{32'hA5A5A5A5}};
    localparam logic [223:0] OTHER  = {7{32'h0BADF00D}};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Host byte order of one 32-bit SHA word, written byte by byte.
    function automatic logic [31:0] ref_word(input logic [31:0] w);
        logic [31:0] r;
`ifdef SHA224_SER_BSWAP_EN
        for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
`else
        r = w;
`endif
        return r;
    endfunction

    task automatic push_digest(input logic [223:0] d);
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(ref_word(d[223-32*i -: 32]));
            idx_q.push_back(i);
        end
    endtask

    function automatic logic [223:0] rand_digest();
        logic [223:0] d;
        for (int i = 0; i < 7; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    // ---------------- sink ready driver ----------------
    initial begin
        bus.word_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (ready_mode)
                0:       bus.word_ready = 1'b1;
                1:       bus.word_ready = (tog % 3 == 0);
                default: bus.word_ready = 1'($urandom_range(0, 1));
            endcase
            tog++;
        end
    end

    // ---------------- monitor / model (mid-cycle) ----------------
    initial begin
        bit exp_v;
        bit exp_dr;
        forever begin
            @(negedge CLK);
            if (!RST && started) begin
                exp_v  = (exp_q.size() > 0);
                exp_dr = (exp_q.size() == 0) || (exp_q.size() == 1 && bus.word_ready);
                check("word_valid",   32'(bus.word_valid),   32'(exp_v));
                check("busy",         32'(bus.busy),         32'(exp_v));
                check("digest_ready", 32'(bus.digest_ready), 32'(exp_dr));
                if (exp_v) begin
                    check("word_out",  bus.word_out,        exp_q[0]);
                    check("word_idx",  32'(bus.word_idx),   32'(idx_q[0]));
                    check("word_last", 32'(bus.word_last),  32'(idx_q[0] == 6));
                    if (bus.word_ready) begin
                        void'(exp_q.pop_front());
                        void'(idx_q.pop_front());
                    end
                end else begin
                    check("word_last_idle", 32'(bus.word_last), 32'd0);
                end
                if (exp_dr && bus.digest_valid) push_digest(bus.digest_in);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_digest(input logic [223:0] d);
        bit ok = 1'b0;
        bus.digest_in    = d;
        bus.digest_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (bus.digest_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("load_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1;
        bus.digest_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge CLK);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST              = 1'b1;
        bus.digest_in    = '0;
        bus.digest_valid = 1'b0;
        #3;
        check("rst_word_valid",   32'(bus.word_valid),   32'd0);
        check("rst_word_out",     bus.word_out,          32'd0);
        check("rst_word_idx",     32'(bus.word_idx),     32'd0);
        check("rst_word_last",    32'(bus.word_last),    32'd0);
        check("rst_busy",         32'(bus.busy),         32'd0);
        check("rst_digest_ready", 32'(bus.digest_ready), 32'd1);
        check("rst_state",        32'(bus.dbg_state),    32'(IDLE));
        #9;
        RST     = 1'b0;
        started = 1'b1;
        @(posedge CLK);
        #1;

        // Known digest, sink always ready.
        ready_mode = 0;
        send_digest(KAT);
        wait_idle();

        // Same digest with the sink stalling in a 1,0,0 pattern.
        ready_mode = 1;
        tog        = 0;
        send_digest(KAT);
        wait_idle();

        // Back-to-back: second digest waits with valid held high.
        ready_mode = 0;
        send_digest(KAT);
        send_digest(PAT_A5);
        wait_idle();

        // A digest offered mid-stream must be ignored.
        send_digest(KAT);
        repeat (3) @(posedge CLK);
        #1;
        bus.digest_in    = OTHER;
        bus.digest_valid = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        bus.digest_valid = 1'b0;
        wait_idle();

        // Asynchronous reset while word 4 is on the output.
        send_digest(KAT);
        repeat (4) @(posedge CLK);
        #2;
        check("pre_rst_idx", 32'(bus.word_idx), 32'd4);
        RST = 1'b1;
        #1;
        check("arst_word_valid",   32'(bus.word_valid),   32'd0);
        check("arst_busy",         32'(bus.busy),         32'd0);
        check("arst_word_idx",     32'(bus.word_idx),     32'd0);
        check("arst_word_last",    32'(bus.word_last),    32'd0);
        check("arst_digest_ready", 32'(bus.digest_ready), 32'd1);
        exp_q.delete();
        idx_q.delete();
        @(negedge CLK);
        #2;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        send_digest(rand_digest());
        wait_idle();

        // Random digests, random sink stalls, random gaps.
        ready_mode = 2;
        for (int n = 0; n < 20; n++) begin
            send_digest(rand_digest());
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            #1;
        end
        wait_idle();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
